// File: rtl/pla_in7_pkg.sv
// ----------------------------------------------------------------------------
// pla_in7_pkg
//   Shared definitions for the in7 PLA response buffer.
//   - Z_W             : width of the PLA response vector (outputs z0..z9).
//   - pla_in7_entry_t : one queued entry, the response plus its change flag.
//   - level_width()   : bits needed to represent an occupancy of 0..depth.
// ----------------------------------------------------------------------------
package pla_in7_pkg;

    localparam int unsigned Z_W = 10;

    typedef struct packed {
        logic [Z_W-1:0] z;
        logic           chg;
    } pla_in7_entry_t;

    // Occupancy runs 0..depth inclusive, so one more value than there are slots.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pla_in7_resp_mem.sv
// ----------------------------------------------------------------------------
// pla_in7_resp_mem
//   DEPTH-entry storage array for the response FIFO.
//   One synchronous write port, one asynchronous read port.
//   Ports:
//     clk      in   write clock, rising edge
//     i_we     in   write enable
//     i_waddr  in   write slot index
//     i_wdata  in   entry to store
//     i_raddr  in   read slot index
//     o_rdata  out  entry at i_raddr (combinational)
// ----------------------------------------------------------------------------
module pla_in7_resp_mem
    import pla_in7_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = pla_in7_entry_t,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  entry_t           i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output entry_t           o_rdata
);

    // NOTE: the array has no reset; validity is tracked by the pointers in the
    // parent, so clearing the storage would only cost reset fan-out.
    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pla_in7_resp_fifo.sv
// ----------------------------------------------------------------------------
// pla_in7_resp_fifo
//   Flow-controlled buffer behind the in7 PLA. Accepts response vectors under
//   valid/ready, tags each with a "differs from previous accepted response"
//   flag, and presents them in order to the consumer.
//   Ports:
//     clk, rst_n   single clock; asynchronous active-low reset
//     in_valid     upstream response valid
//     in_ready     not full (registered state only)
//     in_z         response vector, bit i = PLA output zi
//     out_valid    head entry valid (not empty)
//     out_ready    consumer takes head entry
//     out_z        head entry response (zero while empty)
//     out_chg      head entry change flag (zero while empty)
//     level        current occupancy 0..DEPTH
//     accept_cnt   responses accepted since reset, saturating
// ----------------------------------------------------------------------------
module pla_in7_resp_fifo
    import pla_in7_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned Z_W   = pla_in7_pkg::Z_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [Z_W-1:0]                  in_z,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [Z_W-1:0]                  out_z,
    output logic                            out_chg,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic [CNT_W-1:0]                accept_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned LVL_W = level_width(DEPTH);

    typedef struct packed {
        logic [Z_W-1:0] z;
        logic           chg;
    } entry_t;

    // Pointers carry one wrap bit above the slot index so full and empty
    // are distinguishable when the indices coincide.
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [Z_W-1:0]   r_last_z;
    logic             r_first;
    logic [CNT_W-1:0] r_accept_cnt;

    logic   w_empty;
    logic   w_full;
    logic   w_push;
    logic   w_pop;
    entry_t w_wr_entry;
    entry_t w_rd_entry;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                     (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);

    assign w_push = in_valid && !w_full;
    assign w_pop  = out_ready && !w_empty;

    // The first response after reset always counts as a change, whatever
    // last_z happens to hold.
    assign w_wr_entry.z   = in_z;
    assign w_wr_entry.chg = r_first || (in_z != r_last_z);

    pla_in7_resp_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[IDX_W-1:0]),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr[IDX_W-1:0]),
        .o_rdata (w_rd_entry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_z     <= '0;
            r_first      <= 1'b1;
            r_accept_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_last_z <= in_z;
                r_first  <= 1'b0;
                if (r_accept_cnt != {CNT_W{1'b1}}) begin
                    r_accept_cnt <= r_accept_cnt + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // in_ready depends only on registered pointers: a pop while full frees
    // the slot for the following cycle, never the current one.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    // Gate the head entry while empty so the outputs are defined (zero) out
    // of reset even though the storage array is never cleared.
    assign out_z   = w_empty ? '0   : w_rd_entry.z;
    assign out_chg = w_empty ? 1'b0 : w_rd_entry.chg;

    assign level      = LVL_W'(r_wr_ptr - r_rd_ptr);
    assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_pla_in7_resp_fifo.sv
// ----------------------------------------------------------------------------
// tb_pla_in7_resp_fifo
//   Scoreboard bench: accepted pushes are modelled into a queue with their
//   expected change flag and popped/compared when the consumer takes them.
//   A second instance with a 4-bit counter exercises saturation.
// ----------------------------------------------------------------------------
module tb_pla_in7_resp_fifo;

    localparam int DEPTH = 4;
    localparam int Z_W   = 10;
    localparam int CNT_W = 16;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [Z_W-1:0] in_z;
    logic           out_valid;
    logic           out_ready;
    logic [Z_W-1:0] out_z;
    logic           out_chg;
    logic [2:0]     level;
    logic [CNT_W-1:0] accept_cnt;

    logic           s_in_valid;
    logic           s_in_ready;
    logic [Z_W-1:0] s_in_z;
    logic           s_out_valid;
    logic           s_out_ready;
    logic [Z_W-1:0] s_out_z;
    logic           s_out_chg;
    logic [2:0]     s_level;
    logic [3:0]     s_accept_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [Z_W:0]   sb_q[$];
    logic [Z_W-1:0] m_last_z;
    logic           m_first;
    logic [CNT_W-1:0] m_cnt;

    pla_in7_resp_fifo #(.DEPTH(DEPTH), .Z_W(Z_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_chg    (out_chg),
        .level      (level),
        .accept_cnt (accept_cnt)
    );

    pla_in7_resp_fifo #(.DEPTH(DEPTH), .Z_W(Z_W), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_z       (s_in_z),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_z      (s_out_z),
        .out_chg    (s_out_chg),
        .level      (s_level),
        .accept_cnt (s_accept_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        sb_q.delete();
        m_last_z = '0;
        m_first  = 1'b1;
        m_cnt    = '0;
    endtask

    task automatic do_reset();
        in_valid    = 1'b0;
        in_z        = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_z      = '0;
        s_out_ready = 1'b0;
        rst_n       = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus with status checks and scoreboard pop/compare.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive_cycle(input logic v, input logic [Z_W-1:0] z, input logic r);
        logic         exp_full;
        logic [Z_W:0] exp_e;
        logic         exp_chg;
        in_valid  = v;
        in_z      = z;
        out_ready = r;
        exp_full  = (sb_q.size() == DEPTH);
        n_checks++;
        if (in_ready !== !exp_full) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, !exp_full);
        end
        n_checks++;
        if (out_valid !== (sb_q.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, sb_q.size() != 0);
        end
        n_checks++;
        if (level !== 3'(sb_q.size())) begin
            n_fail++;
            $display("FAIL level: got %0d expected %0d", level, sb_q.size());
        end
        n_checks++;
        if (accept_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL accept_cnt: got %0d expected %0d", accept_cnt, m_cnt);
        end
        if (r && sb_q.size() != 0) begin
            exp_e = sb_q.pop_front();
            n_checks++;
            if ({out_z, out_chg} !== exp_e) begin
                n_fail++;
                $display("FAIL pop_data: got z=%h chg=%b expected z=%h chg=%b",
                         out_z, out_chg, exp_e[Z_W:1], exp_e[0]);
            end
        end
        if (v && !exp_full) begin
            exp_chg = m_first | (z != m_last_z);
            sb_q.push_back({z, exp_chg});
            m_last_z = z;
            m_first  = 1'b0;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid    = 1'b0;
        in_z        = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_z      = '0;
        s_out_ready = 1'b0;
        rst_n       = 1'b0;
        model_clear();
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_z !== '0) begin n_fail++; $display("FAIL reset_out_z: got %h expected 000", out_z); end
        n_checks++;
        if (out_chg !== 1'b0) begin n_fail++; $display("FAIL reset_out_chg: got %b expected 0", out_chg); end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++;
        if (accept_cnt !== '0) begin n_fail++; $display("FAIL reset_accept_cnt: got %0d expected 0", accept_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        do_reset();
        drive_cycle(1'b1, 10'h0A5, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_z !== 10'h0A5 || out_chg !== 1'b1 ||
            level !== 3'd1 || accept_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL single_push: got v=%b z=%h chg=%b lvl=%0d cnt=%0d expected v=1 z=0a5 chg=1 lvl=1 cnt=1",
                     out_valid, out_z, out_chg, level, accept_cnt);
        end
        drive_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_change_flag();
        logic [Z_W-1:0] cz [3];
        logic           cc [3];
        cz = '{10'h0A5, 10'h0A5, 10'h3FF};
        cc = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, cz[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_z !== cz[i] || out_chg !== cc[i]) begin
                n_fail++;
                $display("FAIL chg_order[%0d]: got z=%h chg=%b expected z=%h chg=%b",
                         i, out_z, out_chg, cz[i], cc[i]);
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
        n_checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL chg_drained: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, level);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) drive_cycle(1'b1, Z_W'(10'h100 + i), 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || level !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state: got rdy=%b lvl=%0d expected rdy=0 lvl=4", in_ready, level);
        end
        drive_cycle(1'b1, 10'h105, 1'b0);
        n_checks++;
        if (level !== 3'd4 || accept_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL full_reject: got lvl=%0d cnt=%0d expected lvl=4 cnt=4", level, accept_cnt);
        end
        drive_cycle(1'b1, 10'h105, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1 || level !== 3'd3) begin
            n_fail++;
            $display("FAIL full_pop_frees: got rdy=%b lvl=%0d expected rdy=1 lvl=3", in_ready, level);
        end
        drive_cycle(1'b1, 10'h105, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || accept_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL full_drained: got v=%b cnt=%0d expected v=0 cnt=5", out_valid, accept_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [Z_W-1:0] z;
        logic [Z_W-1:0] prev;
        do_reset();
        drive_cycle(1'b1, 10'h011, 1'b0);
        drive_cycle(1'b1, 10'h022, 1'b0);
        prev = 10'h022;
        for (int i = 0; i < 100; i++) begin
            z = ($urandom_range(0, 3) == 0) ? prev : Z_W'($urandom);
            n_checks++;
            if (level !== 3'd2) begin
                n_fail++;
                $display("FAIL stream_level[%0d]: got %0d expected 2", i, level);
            end
            drive_cycle(1'b1, z, 1'b1);
            prev = z;
        end
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drained: got v=%b left=%0d expected v=0 left=0", out_valid, sb_q.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_cycle(1'b1, 10'h011, 1'b0);
        drive_cycle(1'b1, 10'h022, 1'b0);
        drive_cycle(1'b1, 10'h155, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || accept_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b lvl=%0d cnt=%0d expected v=0 lvl=0 cnt=0",
                     out_valid, level, accept_cnt);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 10'h155, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_z !== 10'h155 || out_chg !== 1'b1 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: got v=%b z=%h chg=%b lvl=%0d expected v=1 z=155 chg=1 lvl=1",
                     out_valid, out_z, out_chg, level);
        end
        drive_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        do_reset();
        s_out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            n_checks++;
            if (s_accept_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, s_accept_cnt, exp_cnt);
            end
            if (i < 20) begin
                s_in_valid = 1'b1;
                s_in_z     = Z_W'(i);
                @(posedge clk);
                #1;
            end
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_change_flag();
        test_full();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
